// File: rtl/id_alu_decode_stage.sv
// id_alu_decode_stage: LoongArch32 ID stage decoding the integer ALU subset into a one-hot bundle held in one pipeline slot.
// Optional build macro ID_INE_TRAP_EN: register an instruction-not-exist flag for unrecognised encodings.
module id_alu_decode_stage #(
   parameter int XLEN     = 32,
   parameter int ALU_OP_W = 12
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                flush,
   input  logic                fs_valid,
   output logic                fs_ready,
   input  logic [XLEN-1:0]     fs_pc,
   input  logic [31:0]         fs_inst,
   output logic [4:0]          rf_raddr1,
   output logic [4:0]          rf_raddr2,
   input  logic [XLEN-1:0]     rf_rdata1,
   input  logic [XLEN-1:0]     rf_rdata2,
   output logic                es_valid,
   input  logic                es_ready,
   output logic [XLEN-1:0]     es_pc,
   output logic [ALU_OP_W-1:0] es_alu_op,
   output logic [XLEN-1:0]     es_alu_src1,
   output logic [XLEN-1:0]     es_alu_src2,
   output logic [4:0]          es_dest,
   output logic                es_gr_we,
   output logic                es_ine
);
   logic [16:0]         op17;
   logic [9:0]          op10;
   logic [6:0]          op7;
   logic                is_add, is_sub, is_slt, is_sltu, is_nor, is_and, is_or, is_xor;
   logic                is_sll, is_srl, is_sra, is_slli, is_srli, is_srai;
   logic                is_slti, is_sltui, is_addi, is_andi, is_ori, is_xori, is_lu12i;
   logic                is_3r, is_shi, is_si12, is_ui12, known, cap;
   logic [ALU_OP_W-1:0] alu_op;
   logic [XLEN-1:0]     src1, src2;
   logic                gr_we;

   assign op17      = fs_inst[31:15];
   assign op10      = fs_inst[31:22];
   assign op7       = fs_inst[31:25];
   assign rf_raddr1 = fs_inst[9:5];
   assign rf_raddr2 = fs_inst[14:10];

   assign is_add   = op17 == 17'h00020;
   assign is_sub   = op17 == 17'h00022;
   assign is_slt   = op17 == 17'h00024;
   assign is_sltu  = op17 == 17'h00025;
   assign is_nor   = op17 == 17'h00028;
   assign is_and   = op17 == 17'h00029;
   assign is_or    = op17 == 17'h0002a;
   assign is_xor   = op17 == 17'h0002b;
   assign is_sll   = op17 == 17'h0002e;
   assign is_srl   = op17 == 17'h0002f;
   assign is_sra   = op17 == 17'h00030;
   assign is_slli  = op17 == 17'h00081;
   assign is_srli  = op17 == 17'h00089;
   assign is_srai  = op17 == 17'h00091;
   assign is_slti  = op10 == 10'h008;
   assign is_sltui = op10 == 10'h009;
   assign is_addi  = op10 == 10'h00a;
   assign is_andi  = op10 == 10'h00d;
   assign is_ori   = op10 == 10'h00e;
   assign is_xori  = op10 == 10'h00f;
   assign is_lu12i = op7 == 7'h0a;

   assign is_3r   = is_add | is_sub | is_slt | is_sltu | is_nor | is_and | is_or | is_xor | is_sll | is_srl | is_sra;
   assign is_shi  = is_slli | is_srli | is_srai;
   assign is_si12 = is_slti | is_sltui | is_addi;
   assign is_ui12 = is_andi | is_ori | is_xori;

   assign alu_op = {is_lu12i, is_sra | is_srai, is_srl | is_srli, is_sll | is_slli,
                    is_xor | is_xori, is_or | is_ori, is_nor, is_and | is_andi,
                    is_sltu | is_sltui, is_slt | is_slti, is_sub, is_add | is_addi};
   assign known  = |alu_op;

   // operand select; unrecognised encodings yield zero operands
   always_comb begin
      src1 = (known & ~is_lu12i) ? rf_rdata1 : '0;
      src2 = is_3r    ? rf_rdata2 :
             is_shi   ? {27'b0, fs_inst[14:10]} :
             is_si12  ? {{20{fs_inst[21]}}, fs_inst[21:10]} :
             is_ui12  ? {20'b0, fs_inst[21:10]} :
             is_lu12i ? {fs_inst[24:5], 12'b0} : '0;
      gr_we = known & (|fs_inst[4:0]);
   end

   assign fs_ready = ~es_valid | es_ready;
   assign cap      = fs_valid & fs_ready & ~flush;

   // single pipeline slot: flush beats capture beats consume, otherwise hold
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         es_valid    <= 1'b0;
         es_pc       <= '0;
         es_alu_op   <= '0;
         es_alu_src1 <= '0;
         es_alu_src2 <= '0;
         es_dest     <= '0;
         es_gr_we    <= 1'b0;
      end else if (flush) begin
         es_valid <= 1'b0;
      end else if (cap) begin
         es_valid    <= 1'b1;
         es_pc       <= fs_pc;
         es_alu_op   <= alu_op;
         es_alu_src1 <= src1;
         es_alu_src2 <= src2;
         es_dest     <= fs_inst[4:0];
         es_gr_we    <= gr_we;
      end else if (es_ready) begin
         es_valid <= 1'b0;
      end
   end

`ifdef ID_INE_TRAP_EN
   // flag unrecognised encodings alongside the bundle; gr_we is already 0 for them
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         es_ine <= 1'b0;
      else if (flush)
         es_ine <= 1'b0;
      else if (cap)
         es_ine <= ~known;
   end
`else
   assign es_ine = 1'b0;
`endif
endmodule

// File: tb/tb_id_alu_decode_stage.sv
// tb_id_alu_decode_stage: directed table-driven check of the ID ALU decode stage.
module tb_id_alu_decode_stage;
   logic        clk = 1'b0;
   logic        resetn, flush, fs_valid, fs_ready, es_valid, es_ready, es_gr_we, es_ine;
   logic [31:0] fs_pc, fs_inst, rf_rdata1, rf_rdata2, es_pc, es_alu_src1, es_alu_src2;
   logic [4:0]  rf_raddr1, rf_raddr2, es_dest;
   logic [11:0] es_alu_op;
   int          checks = 0;
   int          errors = 0;

`ifdef ID_INE_TRAP_EN
   localparam bit INE = 1'b1;
`else
   localparam bit INE = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] inst;
      logic [11:0] op;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [4:0]  dest;
      logic        we;
   } vec_t;

   vec_t vecs [15];

   id_alu_decode_stage dut (
      .clk(clk), .resetn(resetn), .flush(flush), .fs_valid(fs_valid), .fs_ready(fs_ready),
      .fs_pc(fs_pc), .fs_inst(fs_inst), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .es_valid(es_valid), .es_ready(es_ready),
      .es_pc(es_pc), .es_alu_op(es_alu_op), .es_alu_src1(es_alu_src1), .es_alu_src2(es_alu_src2),
      .es_dest(es_dest), .es_gr_we(es_gr_we), .es_ine(es_ine)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rf_val(input logic [4:0] a);
      return a == 5'd0 ? 32'd0 : a == 5'd1 ? 32'd5 : a == 5'd2 ? 32'd7 : 32'h1000 + {27'b0, a};
   endfunction

   // register-file model: r1=5, r2=7, other registers distinct
   always_comb begin
      rf_rdata1 = rf_val(rf_raddr1);
      rf_rdata2 = rf_val(rf_raddr2);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bundle(input string tag, input logic [31:0] pc, input logic [11:0] op,
                             input logic [31:0] s1, input logic [31:0] s2);
      chk({tag, "_valid"}, {31'b0, es_valid}, 32'd1);
      chk({tag, "_pc"}, es_pc, pc);
      chk({tag, "_op"}, {20'b0, es_alu_op}, {20'b0, op});
      chk({tag, "_src1"}, es_alu_src1, s1);
      chk({tag, "_src2"}, es_alu_src2, s2);
   endtask

   initial begin
      vecs[0]  = '{32'h00100823, 12'h001, 32'd5, 32'd7,        5'd3,  1'b1};
      vecs[1]  = '{32'h142468A4, 12'h800, 32'd0, 32'h12345000, 5'd4,  1'b1};
      vecs[2]  = '{32'h02BFFC25, 12'h001, 32'd5, 32'hFFFFFFFF, 5'd5,  1'b1};
      vecs[3]  = '{32'h00110446, 12'h002, 32'd7, 32'd5,        5'd6,  1'b1};
      vecs[4]  = '{32'h00180827, 12'h400, 32'd5, 32'd7,        5'd7,  1'b1};
      vecs[5]  = '{32'h00488C48, 12'h400, 32'd7, 32'd3,        5'd8,  1'b1};
      vecs[6]  = '{32'h0040FC29, 12'h100, 32'd5, 32'd31,       5'd9,  1'b1};
      vecs[7]  = '{32'h037FFC2A, 12'h010, 32'd5, 32'h00000FFF, 5'd10, 1'b1};
      vecs[8]  = '{32'h0220004B, 12'h004, 32'd7, 32'hFFFFF800, 5'd11, 1'b1};
      vecs[9]  = '{32'h00158820, 12'h080, 32'd5, 32'd7,        5'd0,  1'b0};
      vecs[10] = '{32'hFFFFFFFF, 12'h000, 32'd0, 32'd0,        5'd31, 1'b0};
      vecs[11] = '{32'h0014082C, 12'h020, 32'd5, 32'd7,        5'd12, 1'b1};
      vecs[12] = '{32'h0012844D, 12'h008, 32'd7, 32'd5,        5'd13, 1'b1};
      vecs[13] = '{32'h03848C4E, 12'h040, 32'd7, 32'h00000123, 5'd14, 1'b1};
      vecs[14] = '{32'h0017882F, 12'h200, 32'd5, 32'd7,        5'd15, 1'b1};

      resetn = 1'b0; flush = 1'b0; fs_valid = 1'b0; es_ready = 1'b0;
      fs_pc = 32'h0; fs_inst = 32'h0;
      tick();
      chk("rst_valid", {31'b0, es_valid}, 32'd0);
      chk("rst_op", {20'b0, es_alu_op}, 32'd0);
      chk("rst_src1", es_alu_src1, 32'd0);
      chk("rst_src2", es_alu_src2, 32'd0);
      chk("rst_pc", es_pc, 32'd0);
      chk("rst_we", {31'b0, es_gr_we}, 32'd0);
      chk("rst_ine", {31'b0, es_ine}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("rst_fs_ready", {31'b0, fs_ready}, 32'd1);

      // back-to-back decode at full throughput
      es_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         fs_valid = 1'b1;
         fs_inst  = vecs[i].inst;
         fs_pc    = 32'h1c000000 + 32'(i * 4);
         tick();
         chk_bundle($sformatf("v%0d", i), 32'h1c000000 + 32'(i * 4), vecs[i].op, vecs[i].s1, vecs[i].s2);
         chk($sformatf("v%0d_dest", i), {27'b0, es_dest}, {27'b0, vecs[i].dest});
         chk($sformatf("v%0d_we", i), {31'b0, es_gr_we}, {31'b0, vecs[i].we});
         chk($sformatf("v%0d_ine", i), {31'b0, es_ine}, {31'b0, INE && vecs[i].op == 12'h0});
         chk($sformatf("v%0d_fs_ready", i), {31'b0, fs_ready}, 32'd1);
      end

      // stall: A held while EX is not ready, then B and C emerge in order
      fs_inst = 32'h00100823; fs_pc = 32'h100;
      tick();
      chk_bundle("stA", 32'h100, 12'h001, 32'd5, 32'd7);
      es_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         fs_inst = c[0] ? 32'hFFFFFFFF : 32'h00110446;
         fs_pc   = 32'h104;
         tick();
         chk($sformatf("st%0d_fs_ready", c), {31'b0, fs_ready}, 32'd0);
         chk_bundle($sformatf("st%0d", c), 32'h100, 12'h001, 32'd5, 32'd7);
         chk($sformatf("st%0d_dest", c), {27'b0, es_dest}, 32'd3);
      end
      fs_inst = 32'h00110446; es_ready = 1'b1;
      tick();
      chk_bundle("stB", 32'h104, 12'h002, 32'd7, 32'd5);
      fs_inst = 32'h142468A4; fs_pc = 32'h108;
      tick();
      chk_bundle("stC", 32'h108, 12'h800, 32'd0, 32'h12345000);
      fs_valid = 1'b0;
      tick();
      chk("drain_valid", {31'b0, es_valid}, 32'd0);

      // flush coincident with a capture on an empty slot
      fs_valid = 1'b1; fs_inst = 32'h00100823; fs_pc = 32'h200; flush = 1'b1;
      tick();
      chk("fl_empty_valid", {31'b0, es_valid}, 32'd0);
      // flush an occupied, stalled slot carrying an unrecognised encoding
      flush = 1'b0; fs_inst = 32'hFFFFFFFF; fs_pc = 32'h204;
      tick();
      chk("ine_cap_valid", {31'b0, es_valid}, 32'd1);
      chk("ine_cap", {31'b0, es_ine}, {31'b0, INE});
      chk("ine_cap_we", {31'b0, es_gr_we}, 32'd0);
      es_ready = 1'b0; flush = 1'b1; fs_inst = 32'h00100823; fs_pc = 32'h208;
      tick();
      chk("fl_full_valid", {31'b0, es_valid}, 32'd0);
      chk("fl_ine", {31'b0, es_ine}, 32'd0);
      flush = 1'b0;

      // asynchronous reset in the middle of a stall
      tick();
      chk_bundle("pre_rst", 32'h208, 12'h001, 32'd5, 32'd7);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, es_valid}, 32'd0);
      chk("mid_rst_op", {20'b0, es_alu_op}, 32'd0);
      chk("mid_rst_pc", es_pc, 32'd0);
      fs_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("post_rst_fs_ready", {31'b0, fs_ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
